// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the single-byte SPI master.
//               Holds the FSM state encoding, the transfer width and the
//               default SCLK half-period divider.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Bits per transfer; the bit counter width is derived from this.
    localparam int SPI_BITS            = 8;

    // Default SCLK half-period in clk cycles (legal range 1..255).
    localparam int SPI_CLK_DIV_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } spi_state_e;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_div
// Description : Half-period tick generator for the SPI master. While enabled
//               it emits a single-cycle tick every CLK_DIV clk cycles; when
//               disabled the count is held at zero so the first tick after
//               enabling always arrives exactly CLK_DIV cycles later.
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               i_en    - count enable from the FSM
//               o_tick  - one-cycle tick at the end of each half-period
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam logic [7:0] c_TERM = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    assign o_tick = i_en && (r_cnt == c_TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (!i_en || o_tick) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule : spi_clk_div
`default_nettype wire

// File: rtl/spi_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_master
// Description : Single-byte SPI master, mode 0 (CPOL=0, CPHA=0). Each accepted
//               start performs one cs_n-framed 8-bit full-duplex transfer and
//               ends with a one-cycle done pulse. done arrives exactly
//               1 + 18*CLK_DIV cycles after the accepting clock edge.
// Build option: SPI_LSB_FIRST_EN - when defined, bit 0 is shifted out first
//               and the first sampled miso bit lands in data_out[0]. Timing
//               and framing are identical in both builds.
// Ports       : clk      - system clock, rising edge
//               rst_n    - asynchronous active-low reset
//               start    - one-cycle request, honoured only in IDLE
//               done     - one-cycle completion pulse
//               data_in  - byte to send, captured when start is accepted
//               data_out - byte received, valid from done until next done
//               sclk     - SPI clock, idles low
//               mosi     - serial data out
//               miso     - serial data in
//               cs_n     - active-low chip select, one window per byte
// Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                done,
    input  logic [SPI_BITS-1:0] data_in,
    output logic [SPI_BITS-1:0] data_out,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso,
    output logic                cs_n
);

    localparam int                 c_CNT_W    = $clog2(SPI_BITS);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(SPI_BITS - 1);

    spi_state_e          r_state;
    spi_state_e          w_next;

    logic [SPI_BITS-1:0] r_tx;
    logic [SPI_BITS-1:0] r_rx;
    logic [SPI_BITS-1:0] r_data_out;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic                r_low_phase;
    logic                r_sclk;
    logic                r_cs_n;
    logic                r_div_en;

    logic                w_tick;
    logic                w_busy;
    logic                w_done;
    logic                w_last_bit;
    logic                w_tx_bit;
    logic [SPI_BITS-1:0] w_tx_shifted;
    logic [SPI_BITS-1:0] w_rx_shifted;

    // ------------------------------------------------------------------
    // Bit ordering. mosi is taken straight from the transmit register so
    // it is a registered, glitch-free output and resets to 0 with it.
    // ------------------------------------------------------------------
`ifdef SPI_LSB_FIRST_EN
    assign w_tx_bit     = r_tx[0];
    assign w_tx_shifted = {1'b0, r_tx[SPI_BITS-1:1]};
    assign w_rx_shifted = {miso, r_rx[SPI_BITS-1:1]};
`else
    assign w_tx_bit     = r_tx[SPI_BITS-1];
    assign w_tx_shifted = {r_tx[SPI_BITS-2:0], 1'b0};
    assign w_rx_shifted = {r_rx[SPI_BITS-2:0], miso};
`endif

    assign w_last_bit = (r_bit_cnt == c_LAST_BIT);

    // ------------------------------------------------------------------
    // Half-period tick source. Its enable is the busy decode delayed by
    // one cycle: cs_n drops on the accepting edge and the divider starts
    // counting one cycle later, which makes SETUP last CLK_DIV+1 cycles
    // and yields the 1 + 18*CLK_DIV start-to-done latency.
    // ------------------------------------------------------------------
    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_div_en),
        .o_tick (w_tick)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = SETUP;
                end
            end
            SETUP: begin
                if (w_tick) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                // Leave only after the low half of the final bit.
                if (w_tick && r_low_phase && w_last_bit) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                if (w_tick) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            SETUP, SHIFT, HOLD: w_busy = 1'b1;
            DONE:               w_done = 1'b1;
            default:            ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift registers, bit counter, sclk and cs_n.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx        <= '0;
            r_rx        <= '0;
            r_data_out  <= '0;
            r_bit_cnt   <= '0;
            r_low_phase <= 1'b0;
            r_sclk      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_div_en    <= 1'b0;
        end else begin
            r_div_en <= w_busy;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_tx        <= data_in;
                        r_cs_n      <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_low_phase <= 1'b0;
                    end
                end
                SETUP: begin
                    // First rising sclk edge; sample the first miso bit.
                    if (w_tick) begin
                        r_sclk <= 1'b1;
                        r_rx   <= w_rx_shifted;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (!r_low_phase) begin
                            // Falling edge: advance mosi, except after the
                            // last bit where mosi holds until the frame ends.
                            r_sclk      <= 1'b0;
                            r_low_phase <= 1'b1;
                            if (!w_last_bit) begin
                                r_tx <= w_tx_shifted;
                            end
                        end else begin
                            r_low_phase <= 1'b0;
                            if (!w_last_bit) begin
                                r_sclk    <= 1'b1;
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                r_rx      <= w_rx_shifted;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_cs_n     <= 1'b1;
                        r_data_out <= r_rx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done     = w_done;
    assign data_out = r_data_out;
    assign sclk     = r_sclk;
    assign mosi     = w_tx_bit;
    assign cs_n     = r_cs_n;

endmodule : spi_byte_master
`default_nettype wire

// File: tb/tb_spi_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_byte_master
// Description : Self-checking bench for spi_byte_master. Instance A uses
//               CLK_DIV=4 with a mode-0 slave model (or loopback); instance B
//               uses CLK_DIV=1 in loopback. Drivers push expected results into
//               per-instance queues; monitors pop and compare on each done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_byte_master;

    localparam int DIV_A = 4;
    localparam int DIV_B = 1;

    typedef struct {
        logic [7:0] dout;
        logic [7:0] seq;
        int         t0;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance A ----------------
    logic       a_start = 1'b0;
    logic [7:0] a_din   = 8'h00;
    logic       a_done;
    logic [7:0] a_dout;
    logic       a_sclk;
    logic       a_mosi;
    logic       a_miso;
    logic       a_cs_n;
    logic       a_loop  = 1'b0;
    logic       s_miso  = 1'b0;

    assign a_miso = a_loop ? a_mosi : s_miso;

    spi_byte_master #(.CLK_DIV(DIV_A)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (a_start),
        .done     (a_done),
        .data_in  (a_din),
        .data_out (a_dout),
        .sclk     (a_sclk),
        .mosi     (a_mosi),
        .miso     (a_miso),
        .cs_n     (a_cs_n)
    );

    // ---------------- instance B (loopback) ----------------
    logic       b_start = 1'b0;
    logic [7:0] b_din   = 8'h00;
    logic       b_done;
    logic [7:0] b_dout;
    logic       b_sclk;
    logic       b_mosi;
    logic       b_cs_n;

    spi_byte_master #(.CLK_DIV(DIV_B)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (b_start),
        .done     (b_done),
        .data_in  (b_din),
        .data_out (b_dout),
        .sclk     (b_sclk),
        .mosi     (b_mosi),
        .miso     (b_mosi),
        .cs_n     (b_cs_n)
    );

    exp_t a_q[$];
    exp_t b_q[$];
    int   a_dones = 0;
    int   b_dones = 0;

    logic [7:0] c_frame [0:4] = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wire order of a logical byte: identity for MSB-first, reversed otherwise.
    function automatic logic [7:0] order(input logic [7:0] b);
`ifdef SPI_LSB_FIRST_EN
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
`else
        return b;
`endif
    endfunction

    // ---------------- mode-0 slave model on instance A ----------------
    logic [7:0] s_resp = 8'h00;
    logic [7:0] s_out_sh = 8'h00;
    logic [7:0] s_seq = 8'h00;
    int         s_rises = 0;
    int         s_windows = 0;
    longint     s_cs_fall = 0, s_cs_rise = 0, s_first_rise = 0, s_last_fall = 0;
    logic [7:0] s_log[$];

    always @(negedge a_cs_n) begin
        s_out_sh  = order(s_resp);
        s_miso    = s_out_sh[7];
        s_rises   = 0;
        s_seq     = 8'h00;
        s_cs_fall = $time;
        s_windows++;
    end
    always @(posedge a_sclk) begin
        s_seq = {s_seq[6:0], a_mosi};
        if (s_rises == 0) s_first_rise = $time;
        s_rises++;
    end
    always @(negedge a_sclk) begin
        s_out_sh    = {s_out_sh[6:0], 1'b0};
        s_miso      = s_out_sh[7];
        s_last_fall = $time;
    end
    always @(posedge a_cs_n) begin
        s_cs_rise = $time;
        if (s_rises == 8) s_log.push_back(order(s_seq));
    end

    // ---------------- capture on instance B ----------------
    logic [7:0] b_seq = 8'h00;
    int         b_rises = 0;
    longint     b_first_rise = 0, b_last_fall = 0;

    always @(negedge b_cs_n) begin
        b_seq   = 8'h00;
        b_rises = 0;
    end
    always @(posedge b_sclk) begin
        b_seq = {b_seq[6:0], b_mosi};
        if (b_rises == 0) b_first_rise = $time;
        b_rises++;
    end
    always @(negedge b_sclk) b_last_fall = $time;

    // ---------------- monitors ----------------
    exp_t a_e;
    always @(negedge clk) begin
        if (rst_n && a_done === 1'b1) begin
            if (a_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_done: got done=1 expected no done");
            end else begin
                a_e = a_q.pop_front();
                a_dones++;
                chk("a_data_out", 32'(a_dout), 32'(a_e.dout));
                chk("a_latency", 32'(cyc - a_e.t0), 32'(1 + 18 * DIV_A));
                chk("a_mosi_seq", 32'(s_seq), 32'(a_e.seq));
                chk("a_sclk_rises", 32'(s_rises), 32'd8);
                chk("a_cs_low_cycles", 32'(int'((s_cs_rise - s_cs_fall) / 10)), 32'(18 * DIV_A + 1));
                chk("a_sclk_span", 32'(int'((s_last_fall - s_first_rise) / 10)), 32'(15 * DIV_A));
            end
        end
    end

    exp_t b_e;
    always @(negedge clk) begin
        if (rst_n && b_done === 1'b1) begin
            if (b_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_done: got done=1 expected no done");
            end else begin
                b_e = b_q.pop_front();
                b_dones++;
                chk("b_data_out", 32'(b_dout), 32'(b_e.dout));
                chk("b_latency", 32'(cyc - b_e.t0), 32'(1 + 18 * DIV_B));
                chk("b_mosi_seq", 32'(b_seq), 32'(b_e.seq));
                chk("b_sclk_rises", 32'(b_rises), 32'd8);
                chk("b_sclk_span", 32'(int'((b_last_fall - b_first_rise) / 10)), 32'(15 * DIV_B));
            end
        end
    end

    // ---------------- drivers (called at a negedge, DUT idle) ----------------
    task automatic issue_a(input logic [7:0] din, input logic [7:0] resp, input bit expect_done);
        exp_t e;
        s_resp  = resp;
        a_din   = din;
        a_start = 1'b1;
        e.dout  = a_loop ? din : resp;
        e.seq   = order(din);
        e.t0    = cyc + 1;
        if (expect_done) a_q.push_back(e);
        @(negedge clk);
        a_start = 1'b0;
        a_din   = ~din;   // later data_in changes must not disturb the transfer
    endtask

    task automatic wait_done_a(input bit poke_in_done);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (a_done === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL a_done_timeout: got no done expected done within 400 cycles");
        end else if (poke_in_done) begin
            a_start = 1'b1;    // must be ignored in the DONE cycle
            a_din   = 8'hEE;
        end
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic issue_b(input logic [7:0] din);
        exp_t e;
        b_din   = din;
        b_start = 1'b1;
        e.dout  = din;
        e.seq   = order(din);
        e.t0    = cyc + 1;
        b_q.push_back(e);
        @(negedge clk);
        b_start = 1'b0;
        b_din   = ~din;
    endtask

    task automatic wait_done_b();
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (b_done === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL b_done_timeout: got no done expected done within 100 cycles");
        end
        @(negedge clk);
    endtask

    task automatic wait_sclk_rises_a(input int n);
        int   rises = 0;
        logic prev  = 1'b0;
        for (int i = 0; i < 400 && rises < n; i++) begin
            @(negedge clk);
            if (a_sclk && !prev) rises++;
            prev = a_sclk;
        end
        if (rises < n) begin
            checks++;
            failures++;
            $display("FAIL a_sclk_rise_timeout: got %0d rises expected %0d", rises, n);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w0;
        int l0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sclk", 32'(a_sclk), 32'd0);
        chk("rst_cs_n", 32'(a_cs_n), 32'd1);
        chk("rst_mosi", 32'(a_mosi), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_data_out", 32'(a_dout), 32'h00);
        chk("rst_b_cs_n", 32'(b_cs_n), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // CLK_DIV=1 loopback
        issue_b(8'h80);
        wait_done_b();
        issue_b(8'h3C);
        wait_done_b();

        // CLK_DIV=4 loopback
        a_loop = 1'b1;
        issue_a(8'hA5, 8'h00, 1'b1);
        wait_done_a(1'b0);
        a_loop = 1'b0;

        // Slave response, with a start poked during DONE
        issue_a(8'h01, 8'h3C, 1'b1);
        wait_done_a(1'b1);

        // Programming frame, each byte issued in the first IDLE cycle
        w0 = s_windows;
        l0 = s_log.size();
        for (int i = 0; i < 5; i++) begin
            issue_a(c_frame[i], 8'hC0 + 8'(i), 1'b1);
            wait_done_a(1'b0);
        end
        chk("frame_windows", 32'(s_windows - w0), 32'd5);
        if (s_log.size() >= l0 + 5) begin
            chk("frame_cmd", 32'(s_log[l0]), 32'h01);
            chk("frame_addr", {s_log[l0+1], s_log[l0+2], s_log[l0+3], s_log[l0+4]}, 32'h1000_0000);
        end else begin
            checks++;
            failures++;
            $display("FAIL frame_log: got %0d bytes expected %0d", s_log.size() - l0, 5);
        end

        // start re-pulsed 10 cycles into a transfer is ignored
        issue_a(8'hFF, 8'h96, 1'b1);
        repeat (9) @(negedge clk);
        a_din   = 8'h00;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_done_a(1'b0);

        // Reset at the 4th sclk rise aborts the transfer
        issue_a(8'h33, 8'h77, 1'b0);
        wait_sclk_rises_a(4);
        rst_n = 1'b0;
        #1;
        chk("abort_sclk", 32'(a_sclk), 32'd0);
        chk("abort_cs_n", 32'(a_cs_n), 32'd1);
        chk("abort_done", 32'(a_done), 32'd0);
        chk("abort_data_out", 32'(a_dout), 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue_a(8'h5A, 8'hA6, 1'b1);
        wait_done_a(1'b0);

        repeat (40) @(negedge clk);
        chk("a_done_count", 32'(a_dones), 32'd9);
        chk("a_queue_empty", 32'(a_q.size()), 32'd0);
        chk("b_done_count", 32'(b_dones), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_spi_byte_master
`default_nettype wire

// File: doc/spi_byte_master.md
Name: spi_byte_master

Overview:
- Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB-first by default.
- Used by the chip-level bench and by host-side logic to push command, address and data bytes into the SoC's SPI programming slave.
- Programming frame: 0x01 followed by 4 address bytes, then 0x02 followed by 4 data bytes, each byte a separate transfer.
- Each `start` pulse performs one framed 8-bit full-duplex transfer and reports completion with a one-cycle `done` pulse.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- done  out  1  one-cycle pulse at end of transfer.
- data_in  in  8  byte to transmit; captured on the cycle start is accepted.
- data_out  out  8  byte received on miso; valid from done, held until the next accepted start completes.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- cs_n  out  1  chip select, active-low, framed per byte.

Behaviour:
- Reset (async assert, sync deassert internally is not required): sclk=0, cs_n=1, mosi=0, done=0, data_out=8'h00, state=IDLE, counters cleared.
- Reset mid-transfer aborts immediately. No done is generated and cs_n returns high.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE, on start=1 at edge T0:
  - latch data_in into the tx shift register;
  - drive cs_n=0 and mosi=data_in[7] on the next cycle;
  - enter SETUP.
- SETUP: wait CLK_DIV cycles with sclk=0, then enter SHIFT.
- SHIFT, repeated 8 times:
  - sclk high for CLK_DIV cycles; miso is sampled into the rx shift register on the cycle sclk rises;
  - sclk low for CLK_DIV cycles; on the falling edge mosi advances to the next bit.
  - After the 8th falling edge, mosi holds the last bit and the state enters HOLD.
- HOLD: CLK_DIV cycles with sclk=0 and cs_n=0.
- DONE, lasting one cycle:
  - cs_n=1, done=1;
  - data_out <= rx shift register;
  - next state IDLE.
- Latency: done is high exactly 1 + 18*CLK_DIV cycles after T0.
- start while not IDLE is ignored. No queueing and no error flag.
- start in the DONE cycle is ignored. The earliest re-accept is the first IDLE cycle after DONE.
- data_in changes after T0 have no effect on the transfer in progress.
- Bit order: data_in[7] first, data_out[7] = first sampled bit.
- sclk and cs_n are registered outputs and glitch-free.

Optional Feature:
- SPI_LSB_FIRST_EN defined: bit 0 is transmitted first and the first sampled miso bit lands in data_out[0].
- Not defined: MSB-first as above.
- Timing and framing are identical in both builds.

Decomposition:
- Package spi_pkg holds:
  - state enum spi_state_e {IDLE, SETUP, SHIFT, HOLD, DONE};
  - SPI_BITS=8;
  - the default divider constant.
- One natural sub-module: spi_clk_div. It is a CLK_DIV-cycle tick generator, enabled by the FSM, that produces the half-period tick driving sclk toggles and state advances.
- The FSM, shift registers and bit counter stay in spi_byte_master.

Test Plan:
- Loopback (CLK_DIV=4), miso tied to mosi, start with data_in=8'hA5:
  - mosi sampled at the 8 sclk rises = 1,0,1,0,0,1,0,1;
  - done after 73 cycles;
  - data_out=8'hA5; cs_n low exactly for the frame.
- Slave model returns 8'h3C while data_in=8'h01: data_out=8'h3C at done; mosi sequence 0,0,0,0,0,0,0,1.
- Programming frame: back-to-back bytes 0x01,0x10,0x00,0x00,0x00, each issued on done:
  - five separate cs_n low windows;
  - slave receives command 0x01 and address 0x1000_0000.
- start pulsed again 10 cycles into a transfer of 8'hFF: ignored; exactly one done; mosi stays 1 for all 8 bits.
- rst_n low at the 4th sclk rise:
  - asynchronously sclk=0, cs_n=1, done=0, data_out=8'h00;
  - after release, a new start with 8'h5A completes normally.
- CLK_DIV=1 with 8'h80: done 19 cycles after T0; sclk toggles every cycle; only the first mosi bit is 1.
